seg_display_scan: RTL and testbench

SEG_DISPLAY_SCAN -- requirements
Module: seg_display_scan

---
 rtl/seg_display_pkg.sv | 23 ++
 rtl/seg_display_scan_if.sv | 21 ++
 rtl/seg7_decode.sv | 11 +
 rtl/seg_display_scan.sv | 122 ++++++++++++
 tb/tb_seg_display_scan.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_display_pkg.sv
// Shared types and constants for the 4-digit multiplexed seven-segment scanner.
// Segment codes are active-low {g,f,e,d,c,b,a}; the dp bit is added by the decoder.
package seg_display_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam int DIGIT_COUNT = 4;

    localparam logic [3:0] DIGITS_OFF = 4'hF;
    localparam logic [7:0] SEGS_OFF   = 8'hFF;

    // Indexed by nibble value: entry [0] is the rightmost element.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/seg_display_scan_if.sv
// Register-write side and display-drive side of the scanner.
// slave: the scanner itself; master: the bus register / observer.
interface seg_display_scan_if;
    logic        disp_we;
    logic [15:0] disp_wdata;
    logic [3:0]  disp_dp;
    logic [3:0]  digit_sel;
    logic [7:0]  seg;
    logic [1:0]  digit_index;
    logic        frame_done;

    modport slave (
        input  disp_we, disp_wdata, disp_dp,
        output digit_sel, seg, digit_index, frame_done
    );

    modport master (
        output disp_we, disp_wdata, disp_dp,
        input  digit_sel, seg, digit_index, frame_done
    );
endinterface

// File: rtl/seg7_decode.sv
// Hex nibble plus decimal point to active-low segment pattern {dp,g,f,e,d,c,b,a}.
// Latency: combinational. Backpressure: none.
module seg7_decode
    import seg_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);
    assign seg = {~dp, SEG_TABLE[nibble]};
endmodule

// File: rtl/seg_display_scan.sv
// Time-multiplexed 4-digit seven-segment scanner with frame-atomic display update.
// Latency: all outputs registered, one cycle behind the scan state; writes land in pending next cycle.
// Backpressure: none; writes always accepted. Optional SEG_ZERO_BLANK_EN suppresses leading zeros.
module seg_display_scan
    import seg_display_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    seg_display_scan_if.slave bus
);
    localparam int            PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] BLANK_LEN  = PW'(BLANK_CYCLES);
    localparam logic [1:0]    LAST_DIGIT = 2'(DIGIT_COUNT - 1);

    scan_state_t   state;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;
    logic [1:0]    digit;
    logic          slot_end;
    logic          frame_end;

    logic [15:0] pend_data;
    logic [3:0]  pend_dp;
    logic [15:0] act_data;
    logic [3:0]  act_dp;

    logic [3:0] nibble;
    logic       dp_bit;
    logic       lead_zero;
    logic [7:0] dec_seg;
    logic [7:0] drive_seg;

    logic [3:0] digit_sel_q;
    logic [7:0] seg_q;
    logic [1:0] digit_index_q;
    logic       frame_done_q;

    assign slot_end  = (presc == PRESC_LAST);
    assign frame_end = slot_end && (digit == LAST_DIGIT);
    assign presc_nxt = slot_end ? '0 : presc + 1'b1;

    assign nibble = act_data[{digit, 2'b00} +: 4];
    assign dp_bit = act_dp[digit];

    seg7_decode u_decode (
        .nibble (nibble),
        .dp     (dp_bit),
        .seg    (dec_seg)
    );

`ifdef SEG_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        lead_zero = 1'b0;
        case (digit)
            2'd1:    lead_zero = (act_data[15:4]  == 12'h000);
            2'd2:    lead_zero = (act_data[15:8]  == 8'h00);
            2'd3:    lead_zero = (act_data[15:12] == 4'h0);
            default: lead_zero = 1'b0;
        endcase
    end
`else
    assign lead_zero = 1'b0;
`endif

    assign drive_seg = lead_zero ? {~dp_bit, 7'h7F} : dec_seg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= BLANK;
            presc         <= '0;
            digit         <= '0;
            pend_data     <= '0;
            pend_dp       <= '0;
            act_data      <= '0;
            act_dp        <= '0;
            digit_sel_q   <= DIGITS_OFF;
            seg_q         <= SEGS_OFF;
            digit_index_q <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            presc <= presc_nxt;
            state <= (presc_nxt < BLANK_LEN) ? BLANK : DRIVE;
            if (slot_end) begin
                digit <= digit + 2'd1;
            end

            if (bus.disp_we) begin
                pend_data <= bus.disp_wdata;
                pend_dp   <= bus.disp_dp;
            end
            // A write landing on the boundary bypasses pending so it is not lost for a frame.
            if (frame_end) begin
                act_data <= bus.disp_we ? bus.disp_wdata : pend_data;
                act_dp   <= bus.disp_we ? bus.disp_dp    : pend_dp;
            end

            digit_index_q <= digit;
            frame_done_q  <= frame_end;
            case (state)
                DRIVE: begin
                    digit_sel_q <= ~(4'b0001 << digit);
                    seg_q       <= drive_seg;
                end
                default: begin
                    digit_sel_q <= DIGITS_OFF;
                    seg_q       <= SEGS_OFF;
                end
            endcase
        end
    end

    assign bus.digit_sel   = digit_sel_q;
    assign bus.seg         = seg_q;
    assign bus.digit_index = digit_index_q;
    assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan with a slot-position reference model (CLK_DIV=8, BLANK_CYCLES=2).
module tb_seg_display_scan;
    localparam int CLK_DIV = 8;
    localparam int BLANK   = 2;
    localparam int FRAME   = CLK_DIV * 4;

    // Standard active-low hex patterns {g,f,e,d,c,b,a}, digits 0..F in order.
    localparam logic [6:0] HEX7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic clk;
    logic rst;
    seg_display_scan_if bus ();

    seg_display_scan #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: t counts clock edges since reset release; the output after edge t shows slot position t.
    int          t;
    logic [15:0] m_pend, m_act;
    logic [3:0]  m_pdp, m_adp;
    logic [3:0]  exp_sel;
    logic [7:0]  exp_seg;
    logic [1:0]  exp_idx;
    logic        exp_fd;

    function automatic logic [7:0] seg_of(input logic [15:0] d, input logic [3:0] dpv, input int dig);
        logic [6:0] c;
        int upper;
        upper = int'(d) >> (4 * dig);
        c = HEX7[upper % 16];
`ifdef SEG_ZERO_BLANK_EN
        if (dig > 0 && upper == 0) c = 7'h7F;
`endif
        return {~dpv[dig], c};
    endfunction

    task automatic model_reset();
        t = 0;
        m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0;
    endtask

    task automatic step(input logic we, input logic [15:0] wd, input logic [3:0] dp);
        int pos, dig;
        logic boundary;
        @(negedge clk);
        bus.disp_we    = we;
        bus.disp_wdata = wd;
        bus.disp_dp    = dp;
        @(posedge clk);
        pos = t % CLK_DIV;
        dig = (t / CLK_DIV) % 4;
        boundary = (pos == CLK_DIV - 1) && (dig == 3);
        exp_idx = dig[1:0];
        exp_fd  = boundary;
        if (pos < BLANK) begin
            exp_sel = 4'hF;
            exp_seg = 8'hFF;
        end else begin
            exp_sel = 4'hF ^ (4'b0001 << dig);
            exp_seg = seg_of(m_act, m_adp, dig);
        end
        if (boundary) begin
            m_act = we ? wd : m_pend;
            m_adp = we ? dp : m_pdp;
        end
        if (we) begin
            m_pend = wd;
            m_pdp  = dp;
        end
        t++;
        #1;
        bus.disp_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.disp_we = 1'b0; bus.disp_wdata = '0; bus.disp_dp = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.digit_sel !== 4'hF) begin bad++; $display("FAIL reset_sel got=%b want=1111", bus.digit_sel); end
        total++; if (bus.seg !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h want=ff", bus.seg); end
        total++; if (bus.digit_index !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", bus.digit_index); end
        total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b want=0", bus.frame_done); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_idle_scan();
        int pulses = 0;
        int last_fd = -1;
        int gap_bad = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 16'h0, 4'h0);
            total++;
            if (bus.digit_sel !== exp_sel || bus.seg !== exp_seg || bus.digit_index !== exp_idx || bus.frame_done !== exp_fd) begin
                bad++;
                $display("FAIL idle t=%0d got sel=%b seg=%h idx=%0d fd=%b want sel=%b seg=%h idx=%0d fd=%b",
                         t, bus.digit_sel, bus.seg, bus.digit_index, bus.frame_done, exp_sel, exp_seg, exp_idx, exp_fd);
            end
            if (bus.frame_done === 1'b1) begin
                if (last_fd >= 0 && i - last_fd != FRAME) gap_bad++;
                last_fd = i;
                pulses++;
            end
        end
        total++; if (pulses != 2 || gap_bad != 0) begin bad++; $display("FAIL frame_period got pulses=%0d gap_errors=%0d want 2/0", pulses, gap_bad); end
    endtask

    // Run one full frame after the next boundary, capturing each digit's DRIVE code.
    task automatic capture_frame(input string name, output logic [7:0] cap [4]);
        while (t % FRAME != 0) begin
            step(1'b0, 16'h0, 4'h0);
            total++;
            if (bus.digit_sel !== exp_sel || bus.seg !== exp_seg || bus.frame_done !== exp_fd) begin
                bad++; $display("FAIL %s_pre t=%0d got sel=%b seg=%h want sel=%b seg=%h", name, t, bus.digit_sel, bus.seg, exp_sel, exp_seg);
            end
        end
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, 16'h0, 4'h0);
            total++;
            if (bus.digit_sel !== exp_sel || bus.seg !== exp_seg || bus.digit_index !== exp_idx) begin
                bad++; $display("FAIL %s t=%0d got sel=%b seg=%h want sel=%b seg=%h", name, t, bus.digit_sel, bus.seg, exp_sel, exp_seg);
            end
            if (i % CLK_DIV == CLK_DIV - 1) cap[i / CLK_DIV] = bus.seg;
        end
    endtask

    task automatic test_write_12af();
        logic [7:0] cap [4];
        step(1'b1, 16'h12AF, 4'b0001);
        capture_frame("w12af", cap);
        total++; if (cap[0] !== 8'h0E) begin bad++; $display("FAIL w12af_d0 got=%h want=0e", cap[0]); end
        total++; if (cap[1] !== 8'h88) begin bad++; $display("FAIL w12af_d1 got=%h want=88", cap[1]); end
        total++; if (cap[2] !== 8'hA4) begin bad++; $display("FAIL w12af_d2 got=%h want=a4", cap[2]); end
        total++; if (cap[3] !== 8'hF9) begin bad++; $display("FAIL w12af_d3 got=%h want=f9", cap[3]); end
    endtask

    task automatic test_midframe_write();
        logic [7:0] cap [4];
        int skip;
        skip = 4 + int'($urandom_range(0, 20));
        for (int i = 0; i < skip; i++) step(1'b0, 16'h0, 4'h0);
        step(1'b1, 16'h1111, 4'h0);
        capture_frame("mid", cap);
        for (int d = 0; d < 4; d++) begin
            total++; if (cap[d] !== 8'hF9) begin bad++; $display("FAIL mid_next_d%0d got=%h want=f9", d, cap[d]); end
        end
    endtask

    task automatic test_boundary_write();
        while (t % FRAME != FRAME - 1) step(1'b0, 16'h0, 4'h0);
        step(1'b1, 16'h0008, 4'h0);
        total++; if (bus.frame_done !== 1'b1 || bus.seg !== 8'hF9) begin
            bad++; $display("FAIL bnd_edge got fd=%b seg=%h want fd=1 seg=f9", bus.frame_done, bus.seg);
        end
        repeat (3) step(1'b0, 16'h0, 4'h0);
        total++; if (bus.digit_sel !== 4'b1110 || bus.seg !== 8'h80) begin
            bad++; $display("FAIL bnd_d0 got sel=%b seg=%h want sel=1110 seg=80", bus.digit_sel, bus.seg);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10 * FRAME; i++) begin
            if ($urandom_range(0, 5) == 0) step(1'b1, 16'($urandom), 4'($urandom));
            else step(1'b0, 16'h0, 4'h0);
            total++;
            if (bus.digit_sel !== exp_sel || bus.seg !== exp_seg || bus.digit_index !== exp_idx || bus.frame_done !== exp_fd) begin
                bad++;
                $display("FAIL rand t=%0d got sel=%b seg=%h idx=%0d fd=%b want sel=%b seg=%h idx=%0d fd=%b",
                         t, bus.digit_sel, bus.seg, bus.digit_index, bus.frame_done, exp_sel, exp_seg, exp_idx, exp_fd);
            end
        end
    endtask

    task automatic test_reset_midslot();
        while (t % FRAME != 2 * CLK_DIV + 4) step(1'b0, 16'h0, 4'h0);
        step(1'b0, 16'h0, 4'h0);
        total++; if (bus.digit_sel !== 4'b1011 || bus.digit_index !== 2'd2) begin
            bad++; $display("FAIL rst_pre got sel=%b idx=%0d want sel=1011 idx=2", bus.digit_sel, bus.digit_index);
        end
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.digit_sel !== 4'hF || bus.seg !== 8'hFF) begin
            bad++; $display("FAIL rst_async got sel=%b seg=%h want sel=1111 seg=ff", bus.digit_sel, bus.seg);
        end
        total++; if (bus.digit_index !== 2'd0 || bus.frame_done !== 1'b0) begin
            bad++; $display("FAIL rst_async_idx got idx=%0d fd=%b want idx=0 fd=0", bus.digit_index, bus.frame_done);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step(1'b0, 16'h0, 4'h0);
        total++; if (bus.digit_sel !== 4'hF || bus.digit_index !== 2'd0) begin
            bad++; $display("FAIL rst_restart got sel=%b idx=%0d want sel=1111 idx=0", bus.digit_sel, bus.digit_index);
        end
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, 16'h0, 4'h0);
            total++;
            if (bus.digit_sel !== exp_sel || bus.seg !== exp_seg || bus.digit_index !== exp_idx || bus.frame_done !== exp_fd) begin
                bad++; $display("FAIL rst_scan t=%0d got sel=%b seg=%h want sel=%b seg=%h", t, bus.digit_sel, bus.seg, exp_sel, exp_seg);
            end
        end
    endtask

    task automatic test_zero_blank();
        logic [7:0] cap [4];
        logic [7:0] want [4];
`ifdef SEG_ZERO_BLANK_EN
        want = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
`else
        want = '{8'hC0, 8'h92, 8'hC0, 8'hC0};
`endif
        step(1'b1, 16'h0050, 4'h0);
        capture_frame("zb", cap);
        for (int d = 0; d < 4; d++) begin
            total++; if (cap[d] !== want[d]) begin bad++; $display("FAIL zb_d%0d got=%h want=%h", d, cap[d], want[d]); end
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_write_12af();
        test_midframe_write();
        test_boundary_write();
        test_random();
        test_reset_midslot();
        test_zero_blank();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
